// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  // Elaboration-time 10**n, used to derive the largest displayable value.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  bcd_digit_t d_adj;

  assign d_adj = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;
  assign d_out = d_adj;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, with overflow and blank mask.
// Leading-zero blanking is built only when LEAD_ZERO_BLANK_EN is defined.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask
);

  // One spare digit in the scratch so values above MAX never wrap during conversion.
  localparam int SCR_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  conv_state_t state_reg, state_next;

  logic [BIN_W-1:0]    shreg_reg;
  logic [SCR_W-1:0]    scratch_reg;
  logic [SCR_W-1:0]    scratch_adj;
  logic [SCR_W-1:0]    scratch_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                ovf_pend_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic                ovf_reg;
  logic [DIGITS-1:0]   mask_reg;
  logic [DIGITS-1:0]   mask_next;
  logic                accept;
  logic                iterate;
  logic                last_iter;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .d_in  (scratch_reg[4*gi +: 4]),
        .d_out (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The top scratch bit is always zero after correction, so the truncation loses nothing.
  assign scratch_next = SCR_W'({scratch_adj, shreg_reg[BIN_W-1]});
  assign last_iter    = (cnt_reg == LAST_CNT);

`ifdef LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == DIGITS - 1) begin : g_top
        assign lead_zero[gi] = (scratch_next[4*gi +: 4] == 4'd0);
      end else begin : g_chain
        assign lead_zero[gi] = (scratch_next[4*gi +: 4] == 4'd0) & lead_zero[gi+1];
      end

      if (gi == 0) begin : g_units
        assign mask_next[gi] = 1'b0;
      end else begin : g_upper
        assign mask_next[gi] = ~ovf_pend_reg & lead_zero[gi];
      end
    end
  endgenerate
`else
  assign mask_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = CONVERT;
      CONVERT: if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    iterate  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      CONVERT: iterate = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg    <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
      mask_reg     <= '0;
    end else begin
      if (accept) begin
        shreg_reg    <= bin_in;
        scratch_reg  <= '0;
        cnt_reg      <= '0;
        ovf_pend_reg <= (64'(bin_in) > MAX_VAL);
      end
      if (iterate) begin
        scratch_reg <= scratch_next;
        shreg_reg   <= {shreg_reg[BIN_W-2:0], 1'b0};
        cnt_reg     <= cnt_reg + CNT_W'(1);
        // Results publish on the same edge as the final shift, so use the shifted value.
        if (last_iter) begin
          bcd_reg  <= ovf_pend_reg ? {DIGITS{4'h9}} : scratch_next[4*DIGITS-1:0];
          ovf_reg  <= ovf_pend_reg;
          mask_reg <= mask_next;
        end
      end
    end
  end

  assign bcd_out    = bcd_reg;
  assign ovf        = ovf_reg;
  assign blank_mask = mask_reg;

endmodule
